// File: rtl/video_mnist_hist_pkg.sv
// Shared definitions for the MNIST number histogram block.
// Contents: Wishbone word-address constants, the CORE_ID value, the
// frame-tracking state enum and a saturating-increment helper.
package video_mnist_hist_pkg;

    localparam logic [31:0] CORE_ID = 32'h4D48_5354;

    localparam int ADR_CORE_ID     = 'h00;
    localparam int ADR_CONTROL     = 'h01;
    localparam int ADR_PARAM_TH    = 'h02;
    localparam int ADR_FRAME_COUNT = 'h03;
    localparam int ADR_STATUS      = 'h04;
    localparam int ADR_ARGMAX      = 'h05;
    localparam int ADR_HIST        = 'h10;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        COUNT    = 1'b1
    } hist_state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/video_mnist_hist_argmax.sv
// Sequential argmax scanner over the latched histogram.
// A start pulse restarts the walk at bin 0; one bin is examined per cycle
// through scan_idx/bin_value, so the result settles NUM_CLASS cycles after
// start. Ties keep the lower index; an all-zero histogram yields 4'hF.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : restart the scan (wins over a scan in progress)
//   bin_value   : value of result[scan_idx], supplied by the parent
//   scan_idx    : bin currently being examined
//   busy        : scan in progress
//   index       : index of the largest bin from the last completed scan
module video_mnist_hist_argmax #(
    parameter int HIST_WIDTH = 20,
    parameter int NUM_CLASS  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HIST_WIDTH-1:0] bin_value,
    output logic [3:0]            scan_idx,
    output logic                  busy,
    output logic [3:0]            index
);

    logic [HIST_WIDTH-1:0] best_val;
    logic [3:0]            best_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            scan_idx <= 4'd0;
            best_val <= '0;
            best_idx <= 4'hF;
            index    <= 4'd0;
        end else if (start) begin
            busy     <= 1'b1;
            scan_idx <= 4'd0;
            best_val <= '0;
            best_idx <= 4'hF;
        end else if (busy) begin
            // Strict greater-than keeps the earliest bin on ties and leaves
            // best_idx at 4'hF when every bin is zero.
            if (bin_value > best_val) begin
                best_val <= bin_value;
                best_idx <= scan_idx;
            end
            if (scan_idx == 4'(NUM_CLASS - 1)) begin
                busy  <= 1'b0;
                index <= (bin_value > best_val) ? scan_idx : best_idx;
            end else begin
                scan_idx <= scan_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/video_mnist_number_histogram.sv
// Per-frame class histogram of the classified MNIST pixel stream.
// The stream passes through one register slice unchanged; pixels whose
// confidence meets the threshold are counted per class, and the histogram
// is latched into the readable result bins at every frame start.
// Optional argmax scanner: define VIDEO_MNIST_NUMBER_HISTOGRAM_ARGMAX_EN.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   s_axi4s_*           : classified pixel input (tuser[0] = frame start)
//   m_axi4s_*           : registered copy of the input stream
//   s_wb_*              : Wishbone slave, word addressed, single-cycle ack
module video_mnist_number_histogram
    import video_mnist_hist_pkg::*;
#(
    parameter int           TUSER_WIDTH   = 1,
    parameter int           TNUMBER_WIDTH = 4,
    parameter int           TCOUNT_WIDTH  = 4,
    parameter int           NUM_CLASS     = 10,
    parameter int           HIST_WIDTH    = 20,
    parameter int           WB_ADR_WIDTH  = 8,
    parameter int           WB_DAT_WIDTH  = 32,
    parameter int           WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter int           INIT_PARAM_TH = 1,
    parameter logic         INIT_ENABLE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
    input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,

    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic                     s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o
);

    localparam logic [31:0] HIST_MAX = 32'((64'd1 << HIST_WIDTH) - 64'd1);

    // Handshake: a beat transfers on a cycle where valid && ready; valid and
    // its data hold until that cycle. The slice accepts whenever its output
    // register is empty or being drained in the same cycle.
    logic s_accept;
    assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_accept       = s_axi4s_tvalid && s_axi4s_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi4s_tvalid  <= 1'b0;
            m_axi4s_tuser   <= '0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tnumber <= '0;
            m_axi4s_tcount  <= '0;
        end else begin
            if (s_axi4s_tready) m_axi4s_tvalid <= s_axi4s_tvalid;
            if (s_accept) begin
                m_axi4s_tuser   <= s_axi4s_tuser;
                m_axi4s_tlast   <= s_axi4s_tlast;
                m_axi4s_tnumber <= s_axi4s_tnumber;
                m_axi4s_tcount  <= s_axi4s_tcount;
            end
        end
    end

    // Registers
    logic                    enable;
    logic [TCOUNT_WIDTH-1:0] param_th;
    logic [TCOUNT_WIDTH-1:0] th_active;
    logic [31:0]             frame_count;
    logic                    status_valid;
    logic [HIST_WIDTH-1:0]   work   [NUM_CLASS];
    logic [HIST_WIDTH-1:0]   result [NUM_CLASS];
    logic [31:0]             argmax_word;

    logic wb_write;
    logic wb_status_read;
    assign wb_write       = s_wb_stb_i && s_wb_we_i && s_wb_sel_i[0];
    assign wb_status_read = s_wb_stb_i && !s_wb_we_i
                            && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_STATUS));

    // Frame-start beats belong to the new frame, so they are judged against
    // the freshly written threshold that th_active is about to take.
    logic                    sof;
    logic [TCOUNT_WIDTH-1:0] th_eff;
    logic                    hit;
    assign sof    = s_accept && s_axi4s_tuser[0];
    assign th_eff = sof ? param_th : th_active;
    assign hit    = enable && (s_axi4s_tcount >= th_eff)
                    && (32'(s_axi4s_tnumber) < 32'(NUM_CLASS));

    // Frame tracking FSM
    hist_state_t state_q;
    hist_state_t state_d;
    logic        do_count;
    logic        do_snap;

    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_SOF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = COUNT;
            COUNT:    state_d = COUNT;
            default:  state_d = WAIT_SOF;
        endcase
    end

    always_comb begin
        do_count = 1'b0;
        do_snap  = 1'b0;
        case (state_q)
            WAIT_SOF: do_count = sof && hit;
            COUNT: begin
                do_count = s_accept && hit;
                do_snap  = sof;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                work[i]   <= '0;
                result[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                if (do_snap) begin
                    result[i] <= work[i];
                    work[i]   <= (do_count && 32'(s_axi4s_tnumber) == 32'(i))
                                 ? HIST_WIDTH'(1) : '0;
                end else if (do_count && 32'(s_axi4s_tnumber) == 32'(i)) begin
                    work[i] <= HIST_WIDTH'(sat_inc(32'(work[i]), HIST_MAX));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable       <= INIT_ENABLE;
            param_th     <= TCOUNT_WIDTH'(INIT_PARAM_TH);
            th_active    <= TCOUNT_WIDTH'(INIT_PARAM_TH);
            frame_count  <= 32'd0;
            status_valid <= 1'b0;
        end else begin
            if (wb_write && s_wb_adr_i == WB_ADR_WIDTH'(ADR_CONTROL))
                enable <= s_wb_dat_i[0];
            if (wb_write && s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH))
                param_th <= s_wb_dat_i[TCOUNT_WIDTH-1:0];
            if (sof) th_active <= param_th;
            if (do_snap) begin
                frame_count  <= frame_count + 32'd1;
                status_valid <= 1'b1;
            end else if (wb_status_read) begin
                status_valid <= 1'b0;
            end
        end
    end

`ifdef VIDEO_MNIST_NUMBER_HISTOGRAM_ARGMAX_EN
    logic [3:0]            scan_idx;
    logic [HIST_WIDTH-1:0] scan_bin;
    logic                  am_busy;
    logic [3:0]            am_index;

    always_comb begin
        scan_bin = '0;
        for (int i = 0; i < NUM_CLASS; i++)
            if (scan_idx == 4'(i)) scan_bin = result[i];
    end

    video_mnist_hist_argmax #(
        .HIST_WIDTH (HIST_WIDTH),
        .NUM_CLASS  (NUM_CLASS)
    ) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .start     (do_snap),
        .bin_value (scan_bin),
        .scan_idx  (scan_idx),
        .busy      (am_busy),
        .index     (am_index)
    );

    assign argmax_word = {am_busy, 27'd0, am_index};
`else
    assign argmax_word = 32'd0;
`endif

    // Wishbone read mux
    assign s_wb_ack_o = s_wb_stb_i;

    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CORE_ID):     s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(ADR_CONTROL):     s_wb_dat_o = WB_DAT_WIDTH'(enable);
            WB_ADR_WIDTH'(ADR_PARAM_TH):    s_wb_dat_o = WB_DAT_WIDTH'(param_th);
            WB_ADR_WIDTH'(ADR_FRAME_COUNT): s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
            WB_ADR_WIDTH'(ADR_STATUS):      s_wb_dat_o = WB_DAT_WIDTH'(status_valid);
            WB_ADR_WIDTH'(ADR_ARGMAX):      s_wb_dat_o = WB_DAT_WIDTH'(argmax_word);
            default: ;
        endcase
        for (int i = 0; i < NUM_CLASS; i++)
            if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_HIST + i))
                s_wb_dat_o = WB_DAT_WIDTH'(result[i]);
    end

    // Byte lanes above 0 and data bits beyond the widest field are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{s_wb_sel_i[WB_SEL_WIDTH-1:1],
                             s_wb_dat_i[WB_DAT_WIDTH-1:TCOUNT_WIDTH]};

endmodule

// File: doc/video_mnist_number_histogram.md
# video_mnist_number_histogram

Per-frame statistics stage directly downstream of `video_mnist_cnn`. It forwards the classified pixel stream (`tuser`/`tlast`/`tnumber`/`tcount`) through one register slice to `video_mnist_color`. It accumulates, for each digit class, the number of pixels whose confidence count meets a threshold, and latches the finished histogram at every frame start. Software reads results over Wishbone.

## Interface
- `TUSER_WIDTH`, 1, user sideband width; bit 0 = frame start
- `TNUMBER_WIDTH`, 4, class index width
- `TCOUNT_WIDTH`, 4, confidence count width
- `NUM_CLASS`, 10, number of valid classes
- `HIST_WIDTH`, 20, histogram bin width; must be ≤ `WB_DAT_WIDTH`
- `WB_ADR_WIDTH`, 8, Wishbone word address width
- `WB_DAT_WIDTH`, 32, Wishbone data width
- `WB_SEL_WIDTH`, `WB_DAT_WIDTH/8`, byte select width
- `INIT_PARAM_TH`, 1, reset value of the count threshold
- `INIT_ENABLE`, 1'b1, reset value of the enable bit

Ports:
- `clk`, in, 1, single clock for stream and Wishbone
- `reset`, in, 1, synchronous, active-high
- `s_axi4s_tuser`, in, `TUSER_WIDTH`, frame start on bit 0
- `s_axi4s_tlast`, in, 1, line end
- `s_axi4s_tnumber`, in, `TNUMBER_WIDTH`, class
- `s_axi4s_tcount`, in, `TCOUNT_WIDTH`, confidence
- `s_axi4s_tvalid` / `s_axi4s_tready`, in / out, 1, handshake
- `m_axi4s_tuser` / `tlast` / `tnumber` / `tcount`, out, same widths as inputs, registered copy
- `m_axi4s_tvalid` / `m_axi4s_tready`, out / in, 1, handshake
- `s_wb_adr_i`, in, `WB_ADR_WIDTH`
- `s_wb_dat_i`, in, `WB_DAT_WIDTH`
- `s_wb_dat_o`, out, `WB_DAT_WIDTH`
- `s_wb_we_i`, in, 1
- `s_wb_sel_i`, in, `WB_SEL_WIDTH`
- `s_wb_stb_i`, in, 1
- `s_wb_ack_o`, out, 1

## Operation
- **Forwarding:** `s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready`. An accepted beat (`s_tvalid && s_tready`) loads the output register. Data is never modified.
- **State machine:**
  - `WAIT_SOF` (after reset): accepted beats are forwarded but not counted. An accepted beat with `tuser[0]=1` moves to `COUNT` and is counted as the first pixel.
  - `COUNT`: an accepted `tuser[0]` beat triggers the snapshot below.
- **Counting:** a beat is counted when all of the following hold: enable=1, `tcount >= th_active`, and `tnumber < NUM_CLASS`. It increments `work[tnumber]`, saturating at 2^HIST_WIDTH−1.
- **Snapshot** on an accepted `tuser[0]` beat in `COUNT`:
  - Copy `work[*]` to `result[*]`.
  - Increment `frame_count` (32-bit, wraps).
  - Set `status.valid=1`.
  - Reload `work` with only the current beat's contribution (one-hot 1, or all zero).
  - Copy `param_th` to `th_active`.
- **Threshold shadowing:** `param_th` writes affect counting only from the next frame start.
- **Wishbone register map** (word addresses):
  - 0x00 `CORE_ID` = 32'h4D48_5354, read-only
  - 0x01 `CONTROL`: bit0 = enable, read/write
  - 0x02 `PARAM_TH`: bits `TCOUNT_WIDTH-1:0`, read/write
  - 0x03 `FRAME_COUNT`, read-only
  - 0x04 `STATUS`: bit0 = valid, read-only. A read clears valid unless a snapshot occurs in the same cycle.
  - 0x05 `ARGMAX`, read-only
  - 0x10+n `HIST[n]` for n < `NUM_CLASS`, read-only, zero-extended
  - All other addresses read 0.
- **Wishbone write enable:** writes take effect when `stb && we && sel[0]`.

## Timing
- Stream latency: 1 cycle. Full throughput with `m_tready=1`. Backpressure propagates combinationally to `s_tready`.
- `s_wb_ack_o = s_wb_stb_i` (same cycle). `s_wb_dat_o` is combinational from registers.
- A write is visible on a read in the next cycle.
- **Reset values:**
  - `m_tvalid=0`; `m_` data = 0
  - all `work` and `result` bins = 0
  - `frame_count=0`, `status.valid=0`
  - `param_th=th_active=INIT_PARAM_TH`, `enable=INIT_ENABLE`
  - `ARGMAX=0`; state = `WAIT_SOF`
- **Reset mid-frame:** everything returns to the reset values. The partial histogram is discarded.
- **Enable cleared mid-frame:** counting stops; the snapshot still occurs at the next frame start.
- **Backpressure stall:** no counting while a beat is not accepted.

## Configuration
- Macro: `VIDEO_MNIST_NUMBER_HISTOGRAM_ARGMAX_EN`.
- **Defined:** after each snapshot, a sequential scanner walks `result[0..NUM_CLASS-1]`, one bin per cycle, and computes the maximum. The lowest index wins ties.
  - The scan ends `NUM_CLASS` cycles after the snapshot.
  - `ARGMAX` = {bit31 busy, bits 3:0 index}. Index reads 4'hF if all bins are 0.
  - A new snapshot during a scan restarts the scan.
- **Undefined:** no scanner logic is built; `ARGMAX` reads 0.

## Structure
- Package `video_mnist_hist_pkg`:
  - register address constants
  - `CORE_ID`
  - state enum (`WAIT_SOF`, `COUNT`)
  - saturating-increment function
- One sub-module, `video_mnist_hist_argmax`: the scanner, instantiated only under the macro.

## Test plan
- **Reset defaults:** after reset, read 0x00 → 32'h4D48_5354; 0x02 → 1; 0x03 → 0; 0x10 → 0; `m_tvalid=0`.
- **Basic histogram:** frame 1 = 640×480 beats with `tnumber=3`, `tcount=5`, `tuser` on beat 0. A second `tuser` beat then gives HIST[3]=307200, other bins 0, `FRAME_COUNT=1`, `STATUS=1`.
- **Pre-SOF and invalid classes:**
  - 10 beats before the first SOF → not counted.
  - Beats with `tnumber=12` → not counted.
  - `tcount=0` with th=1 → not counted.
- **Threshold shadowing:** write `PARAM_TH=6` mid-frame with `tcount=5` beats. The current frame still counts them; the next frame counts 0.
- **Backpressure:** random `m_tready` at 50%. Output beat sequence equals input, no drops or duplicates, and the histogram matches a reference count.
- **Argmax (macro defined):** bins {2:100, 7:100, 5:40}. ARGMAX reads busy=1 right after the snapshot, then 0x0000_0002 after 10 cycles. An all-zero frame gives 0x0000_000F.
